// File: rtl/fir_coeff_seq.sv
// Coefficient load / read-burst sequencer driving the transposed FIR bank controller bus.
// Define COEFF_SEQ_CHECKSUM_EN to add oCoeffSum, a wrapping sum of the words accepted in the last load.
module fir_coeff_seq #(
    parameter int P_NUM_COEFF  = 40,
    parameter int P_BANK_DEPTH = 10,
    parameter int P_DW         = 16
) (
    input  logic            iClk_12M,
    input  logic            iRsn,
    input  logic            iLoadStart,
    input  logic            iCoeffValid,
    input  logic [P_DW-1:0] iCoeffData,
    output logic            oCoeffReady,
    input  logic            iSampleStrobe,
    output logic            oCoeffiUpdateFlag,
    output logic            oCsnRam,
    output logic            oWrnRam,
    output logic [3:0]      oAddrRam,
    output logic [P_DW-1:0] oWrDtRam,
    output logic [5:0]      oNumOfCoeff,
    output logic            oLoadDone,
`ifdef COEFF_SEQ_CHECKSUM_EN
    output logic            oBusy,
    output logic [P_DW-1:0] oCoeffSum
`else
    output logic            oBusy
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_LOAD_END = 3'd2;
    localparam logic [2:0] S_RUN_WAIT = 3'd3;
    localparam logic [2:0] S_RUN_READ = 3'd4;
    localparam logic [2:0] S_RELOAD   = 3'd5;

    localparam logic [5:0] NUM_COEFF = 6'(P_NUM_COEFF);
    localparam logic [3:0] ADDR_LAST = 4'(P_BANK_DEPTH - 1);

    logic [2:0]      state_q, state_d;
    logic [5:0]      idx_q, idx_d;
    logic [3:0]      waddr_q, waddr_d;
    logic            pend_q, pend_d;
    logic            flag_q, flag_d;
    logic            csn_q, csn_d;
    logic            wrn_q, wrn_d;
    logic [3:0]      addr_q, addr_d;
    logic [P_DW-1:0] data_q, data_d;
    logic [5:0]      num_q, num_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            hs;

    // ready_q is only ever set while in LOAD, so it alone qualifies a handshake.
    assign hs = ready_q & iCoeffValid;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        waddr_d = waddr_q;
        pend_d  = pend_q;
        flag_d  = flag_q;
        csn_d   = 1'b1;
        wrn_d   = 1'b1;
        addr_d  = addr_q;
        data_d  = data_q;
        num_d   = num_q;
        ready_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                flag_d = 1'b0;
                if (iLoadStart) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    waddr_d = '0;
                    flag_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (idx_q == NUM_COEFF) begin
                    state_d = S_LOAD_END;
                    flag_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    flag_d = 1'b1;
                    if (hs) begin
                        csn_d   = 1'b0;
                        wrn_d   = 1'b0;
                        data_d  = iCoeffData;
                        num_d   = idx_q;
                        addr_d  = waddr_q;
                        idx_d   = idx_q + 6'd1;
                        waddr_d = (waddr_q == ADDR_LAST) ? 4'd0 : waddr_q + 4'd1;
                    end
                    ready_d = (idx_d < NUM_COEFF);
                end
            end
            S_LOAD_END: begin
                state_d = S_RUN_WAIT;
                flag_d  = 1'b0;
                num_d   = '0;
                pend_d  = 1'b0;
            end
            S_RUN_WAIT: begin
                flag_d = 1'b0;
                num_d  = '0;
                // A reload request beats a sample strobe arriving in the same cycle.
                if (iLoadStart || pend_q) begin
                    state_d = S_RELOAD;
                    flag_d  = 1'b1;
                    wrn_d   = 1'b0;
                    pend_d  = 1'b0;
                end else if (iSampleStrobe) begin
                    state_d = S_RUN_READ;
                    csn_d   = 1'b0;
                    addr_d  = '0;
                end
            end
            S_RUN_READ: begin
                flag_d = 1'b0;
                if (iLoadStart) pend_d = 1'b1;
                if (addr_q == ADDR_LAST) begin
                    state_d = S_RUN_WAIT;
                end else begin
                    csn_d  = 1'b0;
                    addr_d = addr_q + 4'd1;
                end
            end
            S_RELOAD: begin
                state_d = S_LOAD;
                flag_d  = 1'b1;
                ready_d = 1'b1;
                idx_d   = '0;
                waddr_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                flag_d  = 1'b0;
            end
        endcase

        busy_d = !((state_d == S_IDLE) || (state_d == S_RUN_WAIT));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            waddr_q <= '0;
            pend_q  <= 1'b0;
            flag_q  <= 1'b0;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            num_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            pend_q  <= pend_d;
            flag_q  <= flag_d;
            csn_q   <= csn_d;
            wrn_q   <= wrn_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            num_q   <= num_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign oCoeffReady       = ready_q;
    assign oCoeffiUpdateFlag = flag_q;
    assign oCsnRam           = csn_q;
    assign oWrnRam           = wrn_q;
    assign oAddrRam          = addr_q;
    assign oWrDtRam          = data_q;
    assign oNumOfCoeff       = num_q;
    assign oLoadDone         = done_q;
    assign oBusy             = busy_q;

`ifdef COEFF_SEQ_CHECKSUM_EN
    logic [P_DW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
            sum_d = '0;
        end else if ((state_q == S_LOAD) && hs) begin
            sum_d = sum_q + iCoeffData;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign oCoeffSum = sum_q;
`endif

endmodule

// File: tb/tb_fir_coeff_seq.sv
// Self-checking bench for fir_coeff_seq: vector table, hand sequences and a randomized run checked
// against a cycle-level reference model. Checksum cases apply when COEFF_SEQ_CHECKSUM_EN is defined.
module tb_fir_coeff_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start = 1'b0;
    logic        coeff_valid = 1'b0;
    logic [15:0] coeff_data = 16'h0;
    logic        strobe = 1'b0;
    logic        ready, flag, csn, wrn, done, busy;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [5:0]  num;
`ifdef COEFF_SEQ_CHECKSUM_EN
    logic [15:0] coeff_sum;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [15:0] words [40];

    always #5 clk = ~clk;

    fir_coeff_seq dut (
        .iClk_12M          (clk),
        .iRsn              (rst_n),
        .iLoadStart        (ld_start),
        .iCoeffValid       (coeff_valid),
        .iCoeffData        (coeff_data),
        .oCoeffReady       (ready),
        .iSampleStrobe     (strobe),
        .oCoeffiUpdateFlag (flag),
        .oCsnRam           (csn),
        .oWrnRam           (wrn),
        .oAddrRam          (addr),
        .oWrDtRam          (wdata),
        .oNumOfCoeff       (num),
        .oLoadDone         (done),
`ifdef COEFF_SEQ_CHECKSUM_EN
        .oBusy             (busy),
        .oCoeffSum         (coeff_sum)
`else
        .oBusy             (busy)
`endif
    );

    typedef struct {
        logic        ls;
        logic        vld;
        logic [15:0] dat;
        logic        stb;
        logic [31:0] exp;
    } vec_t;

    // Packed view: {flag, csn, wrn, ready, busy, done, addr[3:0], num[5:0], data[15:0]}
    function automatic logic [31:0] mk(input logic f, input logic c, input logic w, input logic r,
                                       input logic b, input logic d, input logic [3:0] a,
                                       input logic [5:0] n, input logic [15:0] dt);
        return {f, c, w, r, b, d, a, n, dt};
    endfunction

    function automatic logic [31:0] pack_out();
        return {flag, csn, wrn, ready, busy, done, addr, num, wdata};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_ctrl(input string name, input logic f, input logic c, input logic w,
                              input logic r, input logic b, input logic d);
        check(name, 32'({flag, csn, wrn, ready, busy, done}), 32'({f, c, w, r, b, d}));
    endtask

    task automatic cycle(input logic ls, input logic v, input logic [15:0] d, input logic s);
        ld_start    = ls;
        coeff_valid = v;
        coeff_data  = d;
        strobe      = s;
        @(posedge clk);
        #1;
        ld_start    = 1'b0;
        coeff_valid = 1'b0;
        strobe      = 1'b0;
    endtask

    // Loads words[0..39]. mode 0: valid every cycle, 1: every 3rd cycle, 2: random.
    // Expectation: the k-th accepted word appears on the bus the next cycle at addr k%10, num k.
    task automatic do_load(input int mode, input bit issue_start);
        int k, writes, run, max_run;
        logic v;
        logic [15:0] sum_m;
        if (issue_start) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b0);
            check_ctrl("load_entry", 1, 1, 1, 1, 1, 0);
`ifdef COEFF_SEQ_CHECKSUM_EN
            check("sum_cleared", 32'(coeff_sum), 32'd0);
`endif
        end
        k = 0; writes = 0; run = 0; max_run = 0; sum_m = 16'h0;
        for (int cyc = 0; cyc < 1000 && k < 40; cyc++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 2);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            cycle(1'b0, v, v ? words[k] : 16'($urandom), 1'b0);
            if (!csn && !wrn) begin
                writes++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (v) begin
                check_ctrl("load_write", 1, 0, 0, (k < 39), 1, 0);
                check("load_addr", 32'(addr), 32'(k % 10));
                check("load_num", 32'(num), 32'(k));
                check("load_data", 32'(wdata), 32'(words[k]));
                sum_m = sum_m + words[k];
                k++;
            end else begin
                check_ctrl("load_gap", 1, 1, 1, 1, 1, 0);
                if (k > 0)
                    check("load_hold", 32'({addr, num, wdata}),
                          32'({4'((k - 1) % 10), 6'(k - 1), words[k - 1]}));
            end
        end
        check("load_timeout", 32'(k), 32'd40);
        cycle(1'b0, 1'b1, 16'h5A5A, 1'b0);
        check_ctrl("load_end", 0, 1, 1, 0, 1, 1);
        check("load_final_num", 32'(num), 32'd39);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check_ctrl("run_wait_entry", 0, 1, 1, 0, 0, 0);
        check("run_wait_num", 32'(num), 32'd0);
        check("load_write_count", 32'(writes), 32'd40);
        if (mode == 0) check("load_write_run", 32'(max_run), 32'd40);
`ifdef COEFF_SEQ_CHECKSUM_EN
        check("load_sum", 32'(coeff_sum), 32'(sum_m));
`endif
    endtask

    // Reference: an accepted strobe yields 10 CSn-low cycles with addr 0..9, then one idle cycle
    // at least; strobes while a burst is on the bus are dropped.
    task automatic run_random(input int n);
        int pos;
        logic s;
        pos = -1;
        for (int c = 0; c < n + 12; c++) begin
            s = (c < n) && ($urandom_range(0, 3) == 0);
            cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), s);
            if (pos >= 0) pos = (pos == 9) ? -1 : pos + 1;
            else if (s)   pos = 0;
            check_ctrl("rand_run", 0, (pos < 0), 1, 0, (pos >= 0), 0);
            if (pos >= 0) check("rand_addr", 32'(addr), 32'(pos));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, mk(0, 1, 1, 0, 0, 0, 4'd0, 6'd0, 16'h0000)};
        tbl[1] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, mk(0, 1, 1, 0, 0, 0, 4'd0, 6'd0, 16'h0000)};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, mk(0, 1, 1, 0, 0, 0, 4'd0, 6'd0, 16'h0000)};
        tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b0, mk(1, 1, 1, 1, 1, 0, 4'd0, 6'd0, 16'h0000)};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, mk(1, 1, 1, 1, 1, 0, 4'd0, 6'd0, 16'h0000)};
        tbl[5] = '{1'b0, 1'b1, 16'h1111, 1'b0, mk(1, 0, 0, 1, 1, 0, 4'd0, 6'd0, 16'h1111)};
        tbl[6] = '{1'b0, 1'b1, 16'h2222, 1'b0, mk(1, 0, 0, 1, 1, 0, 4'd1, 6'd1, 16'h2222)};
        tbl[7] = '{1'b1, 1'b0, 16'h0000, 1'b0, mk(1, 1, 1, 1, 1, 0, 4'd1, 6'd1, 16'h2222)};
        tbl[8] = '{1'b0, 1'b1, 16'h3333, 1'b0, mk(1, 0, 0, 1, 1, 0, 4'd2, 6'd2, 16'h3333)};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, mk(1, 1, 1, 1, 1, 0, 4'd2, 6'd2, 16'h3333)};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", pack_out(), mk(0, 1, 1, 0, 0, 0, 4'd0, 6'd0, 16'h0));
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].ls, tbl[i].vld, tbl[i].dat, tbl[i].stb);
            check($sformatf("vec%0d", i), pack_out(), tbl[i].exp);
        end

        // Reset mid-load aborts immediately
        #2 rst_n = 1'b0;
        #1 check("reset_mid_load", pack_out(), mk(0, 1, 1, 0, 0, 0, 4'd0, 6'd0, 16'h0));
        @(negedge clk) rst_n = 1'b1;

        // T2: 0x0001..0x0028 back-to-back
        for (int i = 0; i < 40; i++) words[i] = 16'(i + 1);
        do_load(0, 1'b1);

        // T4: strobe in RUN_WAIT, second strobe mid-burst ignored
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_ctrl("burst_start", 0, 0, 1, 0, 1, 0);
        check("burst_addr0", 32'(addr), 32'd0);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b0, 1'b0, 16'h0, (i == 3));
            check_ctrl("burst_ctrl", 0, 0, 1, 0, 1, 0);
            check("burst_addr", 32'(addr), 32'(i));
        end
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check_ctrl("burst_end", 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b0);
            check_ctrl("no_extra_burst", 0, 1, 1, 0, 0, 0);
        end

        // T5: load start while the burst shows addr 4
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check("t5_addr0", 32'(addr), 32'd0);
        for (int i = 1; i < 10; i++) begin
            cycle((i == 5), 1'b0, 16'h0, 1'b0);
            check_ctrl("t5_burst", 0, 0, 1, 0, 1, 0);
            check("t5_addr", 32'(addr), 32'(i));
        end
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check_ctrl("t5_run_wait", 0, 1, 1, 0, 0, 0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check_ctrl("t5_reload", 1, 1, 0, 0, 1, 0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check_ctrl("t5_load", 1, 1, 1, 1, 1, 0);
`ifdef COEFF_SEQ_CHECKSUM_EN
        check("t5_sum_cleared", 32'(coeff_sum), 32'd0);
`endif
        // T3: valid every 3rd cycle, random words
        for (int i = 0; i < 40; i++) words[i] = 16'($urandom);
        do_load(1, 1'b0);

        // Strobe and load start together in RUN_WAIT: reload wins
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        check_ctrl("both_reload", 1, 1, 0, 0, 1, 0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check_ctrl("both_load", 1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 40; i++) words[i] = 16'($urandom);
        do_load(2, 1'b0);

        run_random(300);

`ifdef COEFF_SEQ_CHECKSUM_EN
        // T6: checksum wrap, cleared between loads, frozen during run
        for (int i = 0; i < 40; i++) words[i] = 16'h0800;
        do_load(0, 1'b1);
        check("t6_sum_4000", 32'(coeff_sum), 32'h4000);
        for (int i = 0; i < 40; i++) words[i] = 16'hFFFF;
        do_load(0, 1'b1);
        check("t6_sum_ffd8", 32'(coeff_sum), 32'hFFD8);
        run_random(30);
        check("t6_sum_frozen", 32'(coeff_sum), 32'hFFD8);
`endif

        // T1: asynchronous reset in the middle of a burst
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        check("t1_pre_addr", 32'(addr), 32'd2);
        #2 rst_n = 1'b0;
        #1 check("t1_async_reset", pack_out(), mk(0, 1, 1, 0, 0, 0, 4'd0, 6'd0, 16'h0));
`ifdef COEFF_SEQ_CHECKSUM_EN
        check("t1_sum_reset", 32'(coeff_sum), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        check_ctrl("t1_idle_ignores_strobe", 0, 1, 1, 0, 0, 0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check_ctrl("t1_idle_to_load", 1, 1, 1, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
